pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC register with a configurable-width PC that has:
- a fetch valid/ready handshake and a stall input,
- prioritised trap, jump and branch redirects resolved from EX,
- misaligned-target detection with a halt state,
- a registered flush pulse for the IF/ID stages.

It sits between the trap/CSR unit, the EX-stage branch resolution logic and the instruction memory request port.

Parameters:
- XLEN, 32, PC and address width.
- RESET_VECTOR, 0, PC value loaded on reset.
- IALIGN, 32, instruction alignment in bits. Legal values are 32 or 16; 16 enables compressed-length advance.

Ports:
- clk input 1: clock.
- rst input 1: synchronous active-high reset.
- stall input 1: hazard stall; blocks sequential advance only.
- fetch_ready input 1: instruction memory accepts the request.
- fetch_valid output 1: request valid.
- pc output XLEN: current fetch address.
- inst_is_16 input 1: fetched instruction is 16-bit. Ignored when IALIGN=32.
- branch input 1: EX instruction is a conditional branch.
- zero input 1: branch condition true.
- jump input 1: EX instruction is JAL/JALR.
- jalr_flag input 1: target is base-relative (JALR).
- ex_pc input XLEN: PC of the resolving EX instruction.
- branch_dest input XLEN: sign-extended immediate offset.
- jump_base input XLEN: rs1 value for JALR.
- trap_valid input 1: trap/mret redirect.
- trap_vector input XLEN: trap/mret target.
- redirect output 1: registered flush pulse.
- misaligned_exc output 1: one-cycle exception pulse.
- misaligned_addr output XLEN: offending target.

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_VECTOR, state=BOOT.
  - fetch_valid=0, redirect=0, misaligned_exc=0, misaligned_addr=0.
  - Reset mid-operation discards any pending redirect or halt.
- States are BOOT, RUN and HALT.
  - BOOT -> RUN unconditionally on the next cycle. fetch_valid is 1 in RUN, 0 in BOOT and HALT.
  - RUN -> HALT on a misaligned control target.
  - HALT -> RUN only on trap_valid.
- Target computation, all arithmetic modulo 2^XLEN:
  - jalr_flag=1: target = (jump_base + branch_dest) with bit0 cleared.
  - Otherwise: target = ex_pc + branch_dest.
- Misaligned check:
  - IALIGN=32: misaligned if target[1] is set.
  - IALIGN=16: never misaligned, because bit0 is already cleared for JALR and is even for JAL/branch.
- ctrl_take = jump | (branch & zero). ctrl_take is evaluated only in RUN.
- Next-PC priority, highest first:
  1. trap_valid (any state): pc = trap_vector with the low log2(IALIGN/8) bits cleared; state = RUN.
  2. ctrl_take with an aligned target: pc = target.
  3. ctrl_take with a misaligned target: pc holds; misaligned_exc=1 and misaligned_addr=target on the next cycle; state = HALT.
  4. fetch fire (fetch_valid & fetch_ready & ~stall): pc += 4, or += 2 when IALIGN=16 and inst_is_16. Wrap-around from all-ones is allowed silently.
  5. Otherwise pc holds.
- Stall never blocks priorities 1–3.
- redirect is 1 in the cycle after any priority-1 or priority-2 update, for exactly one cycle. Back-to-back redirects produce consecutive pulses.
- A redirect while fetch_valid=1 and fetch_ready=0 changes pc with fetch_valid held high. The abandoned request is squashed by the redirect pulse downstream.
- trap_valid and ctrl_take in the same cycle: the trap wins, and no misaligned_exc is raised.
- trap_valid in BOOT: the trap is taken and state goes straight to RUN.
- Latency: every pc update is visible the cycle after the deciding edge. There are no combinational paths from the redirect inputs to pc.

Optional Feature:
PC_PERF_EN
- Defined: adds three XLEN-wide output counters, perf_fetch_cnt, perf_redirect_cnt and perf_misalign_cnt.
  - They count fetch fires, redirect pulses and misaligned_exc pulses respectively.
  - They are cleared by rst and wrap at 2^XLEN.
- Undefined: the ports and logic are absent. Core behaviour is identical either way.

Decomposition:
- pc_pkg holds:
  - the state enum (PC_BOOT, PC_RUN, PC_HALT),
  - the legal IALIGN constants,
  - an alignment-mask function of XLEN and IALIGN.
- Sub-module pc_target_calc is purely combinational. Inputs: jalr_flag, ex_pc, branch_dest, jump_base. Outputs: target and misaligned.
- pc_gen keeps the state register, priority mux, pulses and counters.

Test Plan:
- Reset/boot: rst held 2 cycles, RESET_VECTOR=0x1000. pc=0x1000 and fetch_valid=0 for one cycle, then fetch_valid=1; with fetch_ready=1, pc steps 0x1004, 0x1008.
- Branch vs stall: stall=1 with pc=0x40, then branch=1, zero=1, ex_pc=0x38, branch_dest=0x20. Next pc=0x58 and redirect=1 for one cycle; the stall is not honoured for the redirect. With zero=0 instead, pc stays at 0x40.
- JALR masking: jump_base=0x201, branch_dest=0x4, jalr_flag=1, IALIGN=16. pc=0x204. The same case with IALIGN=32 and jump_base=0x203 gives target 0x206: misaligned_exc pulses with addr 0x206, pc holds, fetch_valid=0 until trap_valid with trap_vector=0x80, then pc=0x80.
- Simultaneous events: trap_valid with trap_vector=0x103 and jump=1 in the same cycle. With IALIGN=32 pc=0x100, with IALIGN=16 pc=0x102; no misaligned_exc.
- Compressed advance and backpressure: IALIGN=16, inst_is_16 alternating 1/0, fetch_ready toggling. pc advances +2, +4 only on fire cycles; pc=0xFFFF_FFFE advancing by 2 wraps to 0x0.
- PC_PERF_EN: 5 fires, 2 redirects and 1 misalign give counters 5/2/1; rst mid-run clears all three to 0.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, legal instruction alignments and the
// address alignment mask helper for the program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    // Legal IALIGN values (instruction alignment in bits).
    localparam int unsigned IALIGN_32 = 32;
    localparam int unsigned IALIGN_16 = 16;

    // Mask that clears the low log2(ialign/8) address bits of an xlen-wide
    // address. Callers truncate the result to their own width (xlen <= 64).
    function automatic logic [63:0] align_mask(input int unsigned xlen,
                                               input int unsigned ialign);
        logic [63:0] m;
        m = (ialign == IALIGN_16) ? ~64'd1 : ~64'd3;
        if (xlen < 64) begin
            m = m & ((64'd1 << xlen) - 64'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational control-transfer target and alignment check
// for branches, JAL and JALR resolved in EX.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned IALIGN = 32
) (
    input  logic            jalr_flag_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] branch_dest_i,
    input  logic [XLEN-1:0] jump_base_i,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    localparam logic [XLEN-1:0] ClearBit0 = ~XLEN'(1);

    // Target select and alignment check; JALR drops bit 0 of the sum.
    always_comb begin
        if (jalr_flag_i) begin
            target_o = (jump_base_i + branch_dest_i) & ClearBit0;
        end else begin
            target_o = ex_pc_i + branch_dest_i;
        end
        // With 16-bit alignment bit 0 is always clear here, so nothing traps.
        misaligned_o = (IALIGN == IALIGN_32) ? target_o[1] : 1'b0;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with stall/handshake, prioritised
// trap/jump/branch redirects, misaligned-target halt and a registered flush
// pulse. Optional performance counters are enabled by defining PC_PERF_EN.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     IALIGN       = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            fetch_ready_i,
    output logic            fetch_valid_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            inst_is_16_i,
    input  logic            branch_i,
    input  logic            zero_i,
    input  logic            jump_i,
    input  logic            jalr_flag_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] branch_dest_i,
    input  logic [XLEN-1:0] jump_base_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_vector_i,
    output logic            redirect_o,
    output logic            misaligned_exc_o,
    output logic [XLEN-1:0] misaligned_addr_o
`ifdef PC_PERF_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt_o,
    output logic [XLEN-1:0] perf_redirect_cnt_o,
    output logic [XLEN-1:0] perf_misalign_cnt_o
`endif
);

    localparam logic [XLEN-1:0] AlignMask = XLEN'(align_mask(XLEN, IALIGN));
    localparam logic [XLEN-1:0] Step4     = XLEN'(4);
    localparam logic [XLEN-1:0] Step2     = XLEN'(2);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] exc_addr_q, exc_addr_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            redirect_q, redirect_d;
    logic            exc_q, exc_d;

    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            ctrl_take;
    logic            fire;
    logic [XLEN-1:0] step;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .jalr_flag_i   (jalr_flag_i),
        .ex_pc_i       (ex_pc_i),
        .branch_dest_i (branch_dest_i),
        .jump_base_i   (jump_base_i),
        .target_o      (target),
        .misaligned_o  (misaligned)
    );

    assign ctrl_take = (state_q == PC_RUN) & (jump_i | (branch_i & zero_i));
    assign fire      = fetch_valid_q & fetch_ready_i & ~stall_i;
    assign step      = ((IALIGN == IALIGN_16) && inst_is_16_i) ? Step2 : Step4;

    // Next-PC priority mux and state transitions.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        exc_addr_d = exc_addr_q;
        redirect_d = 1'b0;
        exc_d      = 1'b0;

        if (state_q == PC_BOOT) begin
            state_d = PC_RUN;
        end

        if (trap_valid_i) begin
            pc_d       = trap_vector_i & AlignMask;
            state_d    = PC_RUN;
            redirect_d = 1'b1;
        end else if (ctrl_take && !misaligned) begin
            pc_d       = target;
            redirect_d = 1'b1;
        end else if (ctrl_take) begin
            // PC holds so the trap handler sees the faulting context.
            exc_d      = 1'b1;
            exc_addr_d = target;
            state_d    = PC_HALT;
        end else if (fire) begin
            pc_d = pc_q + step;
        end

        fetch_valid_d = (state_d == PC_RUN);
    end

    // State, PC and registered pulse outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= PC_BOOT;
            pc_q          <= RESET_VECTOR;
            exc_addr_q    <= '0;
            fetch_valid_q <= 1'b0;
            redirect_q    <= 1'b0;
            exc_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            exc_addr_q    <= exc_addr_d;
            fetch_valid_q <= fetch_valid_d;
            redirect_q    <= redirect_d;
            exc_q         <= exc_d;
        end
    end

    assign fetch_valid_o     = fetch_valid_q;
    assign pc_o              = pc_q;
    assign redirect_o        = redirect_q;
    assign misaligned_exc_o  = exc_q;
    assign misaligned_addr_o = exc_addr_q;

`ifdef PC_PERF_EN
    logic [XLEN-1:0] perf_fetch_q, perf_redirect_q, perf_misalign_q;

    // Event counters: fetch fires and the visible redirect/exception pulses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_fetch_q    <= '0;
            perf_redirect_q <= '0;
            perf_misalign_q <= '0;
        end else begin
            perf_fetch_q    <= perf_fetch_q + XLEN'(fire);
            perf_redirect_q <= perf_redirect_q + XLEN'(redirect_q);
            perf_misalign_q <= perf_misalign_q + XLEN'(exc_q);
        end
    end

    assign perf_fetch_cnt_o    = perf_fetch_q;
    assign perf_redirect_cnt_o = perf_redirect_q;
    assign perf_misalign_cnt_o = perf_misalign_q;
`endif

endmodule
